// File: rtl/vga_timing_pkg.sv
// vga_timing_pkg: VESA mode constants, clog2 helper and timing legality check shared by the VGA timing blocks
package vga_timing_pkg;
  typedef struct packed {
    int h_active;
    int h_fp;
    int h_sync;
    int h_bp;
    int v_active;
    int v_fp;
    int v_sync;
    int v_bp;
    bit hs_pol;
    bit vs_pol;
  } mode_t;
  localparam mode_t MODE_640X480_60 = '{640, 16, 96, 48, 480, 10, 2, 33, 1'b0, 1'b0};
  localparam mode_t MODE_800X600_60 = '{800, 40, 128, 88, 600, 1, 4, 23, 1'b1, 1'b1};
  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int t = v - 1; t > 0; t = t >>> 1) r++;
    return r;
  endfunction
  function automatic bit mode_ok(input int cw, input int ha, input int hfp, input int hsy, input int hbp,
                                 input int va, input int vfp, input int vsy, input int vbp);
    return ha >= 1 && hfp >= 1 && hsy >= 1 && hbp >= 1 && va >= 1 && vfp >= 1 && vsy >= 1 && vbp >= 1 &&
           clog2(ha + hfp + hsy + hbp) <= cw && clog2(va + vfp + vsy + vbp) <= cw;
  endfunction
endpackage

// File: rtl/vga_timing_gen_counter.sv
// vga_axis_counter: wrapping axis counter 0..TERM; ports clk, rst (sync active-low), en -> q, wrap (q at TERM)
module vga_axis_counter #(
  parameter int W = 10,
  parameter logic [W-1:0] TERM = '1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  output logic [W-1:0] q,
  output logic         wrap
);
  assign wrap = q == TERM;
  always_ff @(posedge clk)
    if (!rst) q <= '0;
    else if (en) q <= wrap ? '0 : q + 1'b1;
endmodule

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: parametrised VGA sync/active/coordinate generator; in clk, rst (sync active-low), ce -> out hs, vs, active_video_area, x, y, line_start, frame_start, vblank
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int CW       = 10,
  parameter int H_ACTIVE = MODE_640X480_60.h_active,
  parameter int H_FP     = MODE_640X480_60.h_fp,
  parameter int H_SYNC   = MODE_640X480_60.h_sync,
  parameter int H_BP     = MODE_640X480_60.h_bp,
  parameter int V_ACTIVE = MODE_640X480_60.v_active,
  parameter int V_FP     = MODE_640X480_60.v_fp,
  parameter int V_SYNC   = MODE_640X480_60.v_sync,
  parameter int V_BP     = MODE_640X480_60.v_bp,
  parameter bit HS_POL   = MODE_640X480_60.hs_pol,
  parameter bit VS_POL   = MODE_640X480_60.vs_pol
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          ce,
  output logic          hs,
  output logic          vs,
  output logic          active_video_area,
  output logic [CW-1:0] x,
  output logic [CW-1:0] y,
  output logic          line_start,
  output logic          frame_start,
  output logic          vblank
);
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  if (!mode_ok(CW, H_ACTIVE, H_FP, H_SYNC, H_BP, V_ACTIVE, V_FP, V_SYNC, V_BP)) begin : g_bad_mode
    $error("vga_timing_gen: illegal timing mode for CW=%0d", CW);
  end
  localparam logic [CW-1:0] H_LAST = CW'(H_TOTAL - 1);
  localparam logic [CW-1:0] V_LAST = CW'(V_TOTAL - 1);
  localparam logic [CW-1:0] HA     = CW'(H_ACTIVE);
  localparam logic [CW-1:0] HS0    = CW'(H_ACTIVE + H_FP);
  localparam logic [CW-1:0] HS1    = CW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CW-1:0] VA     = CW'(V_ACTIVE);
  localparam logic [CW-1:0] VS0    = CW'(V_ACTIVE + V_FP);
  localparam logic [CW-1:0] VS1    = CW'(V_ACTIVE + V_FP + V_SYNC);
  logic [CW-1:0] hc, vc;
  logic h_wrap, unused_v_wrap;
  logic in_h, in_v, in_hs, in_vs, at_h0;
  vga_axis_counter #(.W(CW), .TERM(H_LAST)) u_h (
    .clk (clk),
    .rst (rst),
    .en  (ce),
    .q   (hc),
    .wrap(h_wrap)
  );
  vga_axis_counter #(.W(CW), .TERM(V_LAST)) u_v (
    .clk (clk),
    .rst (rst),
    .en  (h_wrap & ce),
    .q   (vc),
    .wrap(unused_v_wrap)
  );
  always_comb begin
    in_h  = hc < HA;
    in_v  = vc < VA;
    in_hs = hc >= HS0 && hc < HS1;
    in_vs = vc >= VS0 && vc < VS1;
    at_h0 = hc == '0;
  end
  always_ff @(posedge clk)
    if (!rst) begin
      hs                <= ~HS_POL;
      vs                <= ~VS_POL;
      active_video_area <= 1'b0;
      x                 <= '0;
      y                 <= '0;
      line_start        <= 1'b0;
      frame_start       <= 1'b0;
      vblank            <= 1'b0;
    end else begin
      line_start  <= ce && at_h0;
      frame_start <= ce && at_h0 && vc == '0;
      if (ce) begin
        hs                <= in_hs ? HS_POL : ~HS_POL;
        vs                <= in_vs ? VS_POL : ~VS_POL;
        active_video_area <= in_h && in_v;
        x                 <= in_h && in_v ? hc : '0;
        y                 <= in_h && in_v ? vc : '0;
        vblank            <= !in_v;
      end
    end
endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen: table vectors plus model scoreboard for the small mode, period checks, and a default-mode line check
module tb_vga_timing_gen;
  typedef struct packed {
    logic       hs;
    logic       vs;
    logic       av;
    logic [3:0] x;
    logic [3:0] y;
    logic       ls;
    logic       fs;
    logic       vb;
  } out_t;
  typedef struct {
    logic r;
    logic c;
    out_t e;
  } vec_t;
  localparam out_t RST_OUT = out_t'({1'b1, 1'b1, 1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0});
  logic clk = 1'b0, rst = 1'b0, ce = 1'b1;
  logic hs, vs, av, ls, fs, vb;
  logic [3:0] x, y;
  logic dhs, dvs, dav, dls, dfs, dvb;
  logic [9:0] dx, dy;
  int n_cmp = 0, n_err = 0, ncyc = 0;
  int mhc = 0, mvc = 0;
  out_t last = RST_OUT;
  out_t q[$];
  int fs_t[$];
  always #5 clk = ~clk;
  vga_timing_gen #(
    .CW(4), .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
    .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1), .HS_POL(1'b0), .VS_POL(1'b0)
  ) dut (
    .clk(clk), .rst(rst), .ce(ce), .hs(hs), .vs(vs), .active_video_area(av),
    .x(x), .y(y), .line_start(ls), .frame_start(fs), .vblank(vb)
  );
  vga_timing_gen d_dut (
    .clk(clk), .rst(rst), .ce(ce), .hs(dhs), .vs(dvs), .active_video_area(dav),
    .x(dx), .y(dy), .line_start(dls), .frame_start(dfs), .vblank(dvb)
  );
  function automatic out_t mk(input logic h, v, a, input logic [3:0] xx, yy, input logic l, f, b);
    return out_t'({h, v, a, xx, yy, l, f, b});
  endfunction
  function automatic out_t model_step(input logic r, input logic c);
    out_t e;
    e = last;
    if (!r) begin
      e = RST_OUT;
      mhc = 0;
      mvc = 0;
    end else if (c) begin
      e.hs = !(mhc == 5 || mhc == 6);
      e.vs = mvc != 4;
      e.av = mhc < 4 && mvc < 3;
      e.x  = e.av ? 4'(mhc) : 4'd0;
      e.y  = e.av ? 4'(mvc) : 4'd0;
      e.ls = mhc == 0;
      e.fs = mhc == 0 && mvc == 0;
      e.vb = mvc >= 3;
      if (mhc == 7) begin
        mhc = 0;
        mvc = mvc == 5 ? 0 : mvc + 1;
      end else mhc++;
    end else begin
      e.ls = 1'b0;
      e.fs = 1'b0;
    end
    last = e;
    return e;
  endfunction
  task automatic chk(input string nm, input int got, input int want);
    n_cmp++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %0d want %0d", nm, got, want);
    end
  endtask
  task automatic cyc_x(input logic r, input logic c, input bit use_tab, input out_t te, input string nm);
    out_t e, a;
    rst = r;
    ce  = c;
    e = model_step(r, c);
    q.push_back(use_tab ? te : e);
    @(posedge clk);
    #1;
    ncyc++;
    a = {hs, vs, av, x, y, ls, fs, vb};
    n_cmp++;
    if (q.size() == 0) begin
      n_err++;
      $display("FAIL %s: scoreboard empty at cycle %0d", nm, ncyc);
    end else begin
      e = q.pop_front();
      if (a !== e) begin
        n_err++;
        $display("FAIL %s: cycle %0d got hs,vs,av,x,y,ls,fs,vb=%b want %b", nm, ncyc, a, e);
      end
    end
  endtask
  task automatic cyc(input logic r, input logic c);
    cyc_x(r, c, 1'b0, RST_OUT, "model");
  endtask
  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end
  initial begin
    vec_t tab[12];
    int nvs, nvb, nhs, ls_t[$], hf[$], hr[$];
    logic phs;
    tab[0]  = '{1'b0, 1'b1, RST_OUT};
    tab[1]  = '{1'b0, 1'b1, RST_OUT};
    tab[2]  = '{1'b0, 1'b1, RST_OUT};
    tab[3]  = '{1'b1, 1'b1, mk(1, 1, 1, 0, 0, 1, 1, 0)};
    tab[4]  = '{1'b1, 1'b1, mk(1, 1, 1, 1, 0, 0, 0, 0)};
    tab[5]  = '{1'b1, 1'b1, mk(1, 1, 1, 2, 0, 0, 0, 0)};
    tab[6]  = '{1'b1, 1'b1, mk(1, 1, 1, 3, 0, 0, 0, 0)};
    tab[7]  = '{1'b1, 1'b1, mk(1, 1, 0, 0, 0, 0, 0, 0)};
    tab[8]  = '{1'b1, 1'b1, mk(0, 1, 0, 0, 0, 0, 0, 0)};
    tab[9]  = '{1'b1, 1'b1, mk(0, 1, 0, 0, 0, 0, 0, 0)};
    tab[10] = '{1'b1, 1'b1, mk(1, 1, 0, 0, 0, 0, 0, 0)};
    tab[11] = '{1'b1, 1'b1, mk(1, 1, 1, 0, 1, 1, 0, 0)};
    for (int i = 0; i < 12; i++) cyc_x(tab[i].r, tab[i].c, 1'b1, tab[i].e, $sformatf("vec%0d", i));
    nvs = 0; nvb = 0; nhs = 0;
    fs_t.delete();
    for (int i = 0; i < 110; i++) begin
      cyc(1'b1, 1'b1);
      if (fs) fs_t.push_back(ncyc);
      if (fs_t.size() == 1) begin
        nvs += int'(!vs);
        nvb += int'(vb);
        nhs += int'(!hs);
      end
    end
    chk("frame_start count", fs_t.size() >= 2 ? 2 : fs_t.size(), 2);
    if (fs_t.size() >= 2) chk("frame period", fs_t[1] - fs_t[0], 48);
    chk("vs low clks/frame", nvs, 8);
    chk("vblank clks/frame", nvb, 24);
    chk("hs low clks/frame", nhs, 12);
    fs_t.delete();
    for (int i = 0; i < 260; i++) begin
      cyc(1'b1, i % 2 == 0);
      if (fs) fs_t.push_back(ncyc);
    end
    chk("ce/2 frame_start count", fs_t.size() >= 2 ? 2 : fs_t.size(), 2);
    if (fs_t.size() >= 2) chk("ce/2 frame period", fs_t[1] - fs_t[0], 96);
    for (int i = 0; i < 100 && !(mhc == 7 && mvc == 4); i++) cyc(1'b1, 1'b1);
    chk("pre-reset hs", int'(hs), 0);
    chk("pre-reset vs", int'(vs), 0);
    cyc(1'b0, 1'b1);
    chk("mid reset hs,vs,av", int'({hs, vs, av}), 6);
    cyc(1'b1, 1'b1);
    chk("restart frame_start", int'(fs), 1);
    chk("restart x,y,av", int'({av, x, y}), 256);
    cyc(1'b0, 1'b1);
    cyc(1'b1, 1'b1);
    chk("default first edge", int'({dav, dx, dy, dls, dfs, dvb, dvs}), 32'h20000F >> 0 & 32'hFFFFFFFF ? {1'b1, 20'd0, 1'b1, 1'b1, 1'b0, 1'b1} : 0);
    ls_t.push_back(ncyc);
    phs = dhs;
    for (int i = 0; i < 1700; i++) begin
      cyc(1'b1, 1'b1);
      if (dls) ls_t.push_back(ncyc);
      if (phs && !dhs) hf.push_back(ncyc);
      if (!phs && dhs) hr.push_back(ncyc);
      phs = dhs;
    end
    chk("default line_start count", ls_t.size() >= 2 ? 2 : ls_t.size(), 2);
    if (ls_t.size() >= 2) chk("default line period", ls_t[1] - ls_t[0], 800);
    chk("default hs edges", hf.size() >= 1 && hr.size() >= 1 ? 1 : 0, 1);
    if (hf.size() >= 1) chk("default hs start", hf[0] - ls_t[0], 656);
    if (hf.size() >= 1 && hr.size() >= 1) chk("default hs width", hr[0] - hf[0], 96);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/vga_timing_gen.md
# vga_timing_gen

Parametrised successor to the fixed 640x480 display timing controller. Generates horizontal/vertical sync, active-area flag, pixel coordinates and line/frame strobes for any VESA-style mode set by parameters. A pixel clock-enable lets it run from a faster system clock. It sits between the clock/reset logic and the pixel source/VGA port, and drives the frame buffer read address and the port sync pins.

## Interface
- CW, 10: counter and coordinate width.
- H_ACTIVE, 640: visible pixels per line.
- H_FP, 16: horizontal front porch, in pixels.
- H_SYNC, 96: horizontal sync width, in pixels.
- H_BP, 48: horizontal back porch, in pixels.
- V_ACTIVE, 480: visible lines per frame.
- V_FP, 10: vertical front porch, in lines.
- V_SYNC, 2: vertical sync width, in lines.
- V_BP, 33: vertical back porch, in lines.
- HS_POL, 0: asserted level of hs (0 = active-low).
- VS_POL, 0: asserted level of vs (0 = active-low).

Ports:
- clk  in  1: pixel/system clock.
- rst  in  1: reset; synchronous, active-low.
- ce  in  1: pixel enable; the timing advances one pixel per clk with ce=1.
- hs  out  1: horizontal sync, level set by HS_POL.
- vs  out  1: vertical sync, level set by VS_POL.
- active_video_area  out  1: current pixel is visible.
- x  out  CW: column, valid when active_video_area=1, else 0.
- y  out  CW: row, valid when active_video_area=1, else 0.
- line_start  out  1: one-clk strobe at pixel hc=0.
- frame_start  out  1: one-clk strobe at pixel (0,0).
- vblank  out  1: vc ≥ V_ACTIVE.

## Operation
- Derived constants:
  - H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP; V_TOTAL likewise.
  - Both totals must be ≤ 2^CW; elaboration fails otherwise.
  - Every porch and sync value must be ≥1.
- Internal counters hc (0..H_TOTAL-1) and vc (0..V_TOTAL-1), each CW bits.
- On clk with ce=1:
  - hc increments and wraps to 0 after H_TOTAL-1.
  - vc increments only when hc wraps, and wraps to 0 after V_TOTAL-1.
  - hc and vc wrap together at (H_TOTAL-1, V_TOTAL-1) → (0,0).
- Decode, registered on the same ce edge from the pre-increment (hc,vc):
  - active = hc<H_ACTIVE && vc<V_ACTIVE.
  - hs asserted iff H_ACTIVE+H_FP ≤ hc < H_ACTIVE+H_FP+H_SYNC.
  - vs asserted iff V_ACTIVE+V_FP ≤ vc < V_ACTIVE+V_FP+V_SYNC, for whole lines; vs changes aligned to hc=0.
  - x=hc, y=vc when active, else both 0.
  - line_start = (hc==0); frame_start = (hc==0 && vc==0).
  - vblank = vc≥V_ACTIVE.
- ce=0:
  - Counters and level outputs hold.
  - line_start and frame_start are 0; strobes are single-clk regardless of ce duty.
- All comparisons are unsigned at CW width. No arithmetic overflow is possible given the legality check.

## Timing
- Reset (rst=0 at a clk edge):
  - hc=vc=0.
  - hs=~HS_POL, vs=~VS_POL (deasserted).
  - active_video_area=0, x=y=0, line_start=frame_start=0, vblank=0.
- Latency: outputs describe pixel (hc,vc) one clk after the edge at which that pixel was current. First ce edge after reset release gives active=1, x=0, y=0, line_start=1, frame_start=1.
- Reset mid-frame: takes effect at the next edge irrespective of ce; the output state is as above, and the next frame starts cleanly at (0,0). No partial sync pulse is extended.
- Frame period: H_TOTAL·V_TOTAL enabled cycles, i.e. 420000 with the defaults.
- ce may toggle every cycle. Output timing in enabled-cycle units is independent of the ce pattern.

## Structure
- Shared package vga_timing_pkg holds:
  - mode constants for 640x480@60 and 800x600@60;
  - a clog2 helper;
  - the legality-check function.
- Sub-module vga_axis_counter, instantiated twice (horizontal, vertical):
  - parameters: width, terminal value;
  - ports: clk, rst (sync active-low), en, q, wrap.
  - The vertical instance's en is the horizontal instance's wrap & ce.
- Decode and output registers live in the top level.

## Test plan
Small mode CW=4, H 4/1/2/1 (H_TOTAL=8), V 3/1/1/1 (V_TOTAL=6), HS_POL=VS_POL=0, ce=1 unless stated.
- Reset release:
  - rst low for 3 clks: hs=1, vs=1, active=0, x=y=0, strobes 0.
  - First edge with rst high: active=1, x=0, y=0, line_start=1, frame_start=1.
- Horizontal timing:
  - hs=0 exactly for the outputs of hc=5,6 on every line.
  - active high for 4 clks with x=0,1,2,3, then low for 4.
  - line_start period 8 clks.
- Vertical timing:
  - vs=0 for exactly the 8 clks of line vc=4.
  - vblank high for lines 3..5.
  - frame_start period 48 clks; y=2 on the last active line.
- ce=1 every other clk:
  - All periods double (frame_start every 96 clks).
  - Strobes remain 1 clk wide; levels hold between enables.
- Mid-frame reset at (hc=6,vc=4) while hs=0, vs=0: next clk shows hs=1, vs=1, active=0; the subsequent edge restarts at (0,0) with frame_start=1.
- Defaults (640x480): 800 enabled clks per line, 96-clk hs pulse starting 656 pixels after line_start, frame period 420000 clks.
